// File: rtl/transmisor_activo.sv
// rtl/transmisor_activo.sv - transmit-side lane framer: COM sync/idle fill plus MSB-first byte serialisation
//
// Purpose:
//   Trains the lane with SYNC_COUNT COM K-symbols, then streams 32-bit words
//   as four data symbols (MSB byte first), filling gaps with COM while idle.
//
// Ports:
//   clk_4f     in   1   symbol clock, one byte per cycle
//   reset      in   1   synchronous, active-high reset
//   tx_enable  in   1   lane enable; low requests shutdown
//   data_in    in   32  word to transmit
//   valid_in   in   1   data_in valid
//   ready_out  out  1   word can be accepted this cycle (from registered state + tx_enable)
//   data_out   out  8   transmitted symbol (registered)
//   k_out      out  1   data_out is a K-character (registered)
//   active_tx  out  1   link trained and carrying data/idle (registered)

module transmisor_activo #(
    parameter int unsigned SYNC_COUNT = 4,
    parameter logic [7:0]  COM_SYMBOL = 8'hBC
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  data_out,
    output logic        k_out,
    output logic        active_tx
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SYNC = 2'd1,
        ST_IDLE = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        k_out_q, k_out_d;
    logic        active_tx_q, active_tx_d;
    logic        accept;

    // The last byte of a word is the only SEND slot that may take a new word,
    // which both gives back-to-back throughput and blocks new words during shutdown.
    assign ready_out = tx_enable &&
                       ((state_q == ST_IDLE) ||
                        (state_q == ST_SEND && byte_idx_q == 2'd3));
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d     = state_q;
        cnt_d       = 4'd0;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        data_out_d  = 8'h00;
        k_out_d     = 1'b0;
        active_tx_d = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (tx_enable) begin
                    // The COM emitted on this edge is the first one counted.
                    state_d = ST_SYNC;
                    cnt_d   = 4'd1;
                end
            end
            ST_SYNC: begin
                if (!tx_enable) begin
                    state_d = ST_OFF;
                end else if (cnt_q == 4'(SYNC_COUNT)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SEND;
                    word_d     = data_in;
                    byte_idx_d = 2'd0;
                end else if (!tx_enable) begin
                    state_d = ST_OFF;
                end
            end
            ST_SEND: begin
                // A started word always completes, regardless of tx_enable.
                if (byte_idx_q != 2'd3) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                end else if (accept) begin
                    word_d     = data_in;
                    byte_idx_d = 2'd0;
                end else if (tx_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_d)
            ST_SYNC, ST_IDLE: begin
                data_out_d = COM_SYMBOL;
                k_out_d    = 1'b1;
            end
            ST_SEND: begin
                case (byte_idx_d)
                    2'd0:    data_out_d = word_d[31:24];
                    2'd1:    data_out_d = word_d[23:16];
                    2'd2:    data_out_d = word_d[15:8];
                    default: data_out_d = word_d[7:0];
                endcase
            end
            default: ;
        endcase
        active_tx_d = (state_d == ST_IDLE) || (state_d == ST_SEND);
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q     <= ST_OFF;
            cnt_q       <= 4'd0;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'd0;
            data_out_q  <= 8'h00;
            k_out_q     <= 1'b0;
            active_tx_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            data_out_q  <= data_out_d;
            k_out_q     <= k_out_d;
            active_tx_q <= active_tx_d;
        end
    end

    assign data_out  = data_out_q;
    assign k_out     = k_out_q;
    assign active_tx = active_tx_q;

endmodule
